// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
//
// Receive side of the parity-protected serial bit link. Bits arrive LSB first:
// WIDTH data bits followed by one parity bit. The data bits are collected in a
// shift register while their XOR is accumulated; when the parity bit arrives
// the word is presented on a valid/ready output register together with a
// parity-error flag. A start-of-frame marker restarts framing at any point,
// and discarding a partial frame that way is reported with a one-cycle pulse.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   in_bit          serial bit
//   in_sof          marks in_bit as data bit 0 of a new frame
//   in_valid        in_bit/in_sof valid
//   in_ready        bit accepted when in_valid && in_ready
//   out_data        received data word
//   out_parity_err  parity check failed for out_data
//   out_valid       out_data/out_parity_err valid
//   out_ready       consumer accepts when out_valid && out_ready
//   out_abort       one-cycle pulse: partial frame discarded by in_sof
//   err_count       saturating count of frames with a parity error
// -----------------------------------------------------------------------------
module serial_parity_checker #(
  parameter int WIDTH      = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_abort,
  output logic [7:0]       err_count
);

  // cnt runs 0..WIDTH-1 while collecting data bits and equals WIDTH while
  // waiting for the parity bit.
  localparam int            CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] PARITY_CNT = CW'(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic             acc;

  logic             in_parity;
  logic             accept;
  logic             take_data;
  logic             load;
  logic             frame_err;
  logic [WIDTH-1:0] bit_sel;

  assign in_parity = (cnt == PARITY_CNT);

  // Data bits never stall. The parity bit is the only one that writes the
  // output register, so it waits until that register is empty or being
  // drained this very cycle.
  assign in_ready  = !in_parity || !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign take_data = accept && !in_sof && !in_parity;
  assign load      = accept && !in_sof && in_parity;

  // Total parity over data plus the incoming parity bit.
  assign frame_err = ((acc ^ in_bit) != ODD_PARITY);

  // One-hot select of the shift register position written by the next data bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sel
      assign bit_sel[gi] = (cnt == CW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      shift          <= '0;
      acc            <= 1'b0;
      out_data       <= '0;
      out_parity_err <= 1'b0;
      out_valid      <= 1'b0;
      out_abort      <= 1'b0;
      err_count      <= 8'd0;
    end else begin
      out_abort <= 1'b0;

      // Drain first; a load later in this block re-asserts out_valid so a
      // simultaneous consume and load leaves no bubble.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && in_sof) begin
        // Restart framing with this bit as data bit 0; anything already
        // collected (data or a pending parity slot) is dropped.
        shift     <= {{(WIDTH-1){1'b0}}, in_bit};
        acc       <= in_bit;
        cnt       <= CW'(1);
        out_abort <= (cnt != '0);
      end else if (take_data) begin
        shift <= (shift & ~bit_sel) | (bit_sel & {WIDTH{in_bit}});
        acc   <= acc ^ in_bit;
        cnt   <= cnt + CW'(1);
      end else if (load) begin
        out_data       <= shift;
        out_parity_err <= frame_err;
        out_valid      <= 1'b1;
        cnt            <= '0;
        acc            <= 1'b0;
        if (frame_err && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// -----------------------------------------------------------------------------
// Testbench for serial_parity_checker. Two instances share the clock and
// reset: index 0 checks even parity, index 1 checks odd parity, both 8 bits.
// Expected words live in per-instance queues filled from whole-word arithmetic
// (popcount of data plus parity bit); a negedge monitor compares the output
// register, the error counter and counts abort pulses.
// -----------------------------------------------------------------------------
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_bit_s   [2];
  logic       in_sof_s   [2];
  logic       in_valid_s [2];
  logic       in_ready_s [2];
  logic [7:0] out_data_s [2];
  logic       perr_s     [2];
  logic       out_valid_s[2];
  logic       out_ready_s[2];
  logic       abort_s    [2];
  logic [7:0] errcnt_s   [2];

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q [2][$];
  int         exp_cnt   [2];
  int         abort_seen[2];
  bit         rand_ready = 1'b0;

  always #5 clk = ~clk;

  serial_parity_checker #(.WIDTH(8), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n),
    .in_bit(in_bit_s[0]), .in_sof(in_sof_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .out_data(out_data_s[0]),
    .out_parity_err(perr_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .out_abort(abort_s[0]),
    .err_count(errcnt_s[0])
  );

  serial_parity_checker #(.WIDTH(8), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n),
    .in_bit(in_bit_s[1]), .in_sof(in_sof_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .out_data(out_data_s[1]),
    .out_parity_err(perr_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .out_abort(abort_s[1]),
    .err_count(errcnt_s[1])
  );

  // Reference rule: the number of ones in data+parity must be even (inst 0)
  // or odd (inst 1).
  function automatic logic exp_err(input logic [7:0] w, input logic p, input int i);
    int ones;
    ones = $countones(w) + int'(p);
    return (ones % 2) != ((i == 1) ? 1 : 0);
  endfunction

  // Monitor: out_valid must track the pending-frame queue, the presented
  // word must be the oldest pending one, err_count must match the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (out_valid_s[i] !== (exp_q[i].size() != 0)) begin
          errors++;
          $display("FAIL mon_valid[%0d] got %b want %b", i, out_valid_s[i], exp_q[i].size() != 0);
        end
        if (out_valid_s[i] === 1'b1 && exp_q[i].size() != 0) begin
          checks++;
          if ({perr_s[i], out_data_s[i]} !== exp_q[i][0]) begin
            errors++;
            $display("FAIL mon_word[%0d] got err=%b data=%h want err=%b data=%h",
                     i, perr_s[i], out_data_s[i], exp_q[i][0][8], exp_q[i][0][7:0]);
          end
          if (out_ready_s[i] === 1'b1) void'(exp_q[i].pop_front());
        end
        checks++;
        if (errcnt_s[i] !== 8'(exp_cnt[i])) begin
          errors++;
          $display("FAIL mon_err_count[%0d] got %0d want %0d", i, errcnt_s[i], exp_cnt[i]);
        end
        if (abort_s[i] === 1'b1) abort_seen[i]++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid_s[i] = 1'b0;
      in_sof_s[i]   = 1'($urandom_range(0, 1));
      in_bit_s[i]   = 1'($urandom_range(0, 1));
      if (rand_ready) out_ready_s[i] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_sof_s[i] = 1'b0;
  endtask

  // Present one bit and hold it until accepted; returns the stall cycles.
  task automatic send_bit(input int i, input logic b, input logic s, output int stalls);
    stalls = 0;
    in_bit_s[i]   = b;
    in_sof_s[i]   = s;
    in_valid_s[i] = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready_s[i] === 1'b1) begin
        @(posedge clk); #1;
        break;
      end
      stalls++;
      if (stalls > 200) begin
        checks++;
        errors++;
        $display("FAIL send_bit_timeout[%0d] got in_ready=0 want 1 within 200 cycles", i);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready_s[i] = 1'($urandom_range(0, 1));
    end
    in_valid_s[i] = 1'b0;
    in_sof_s[i]   = 1'b0;
    if (rand_ready) out_ready_s[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input int i, input logic [7:0] w, input logic p,
                            input logic sof, input bit gaps, output int stalls);
    int st;
    logic e;
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      send_bit(i, w[k], (k == 0) ? sof : 1'b0, st);
      stalls += st;
      if (gaps && $urandom_range(0, 3) == 0) idle(i, $urandom_range(1, 3));
    end
    send_bit(i, p, 1'b0, st);
    stalls += st;
    e = exp_err(w, p, i);
    exp_q[i].push_back({e, w});
    if (e && exp_cnt[i] < 255) exp_cnt[i]++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_bit_s[i] = 1'b0; in_sof_s[i] = 1'b0; in_valid_s[i] = 1'b0;
      out_ready_s[i] = 1'b1; exp_cnt[i] = 0; abort_seen[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid_s[i], out_data_s[i], perr_s[i], abort_s[i], errcnt_s[i], in_ready_s[i]} !== 19'b1) begin
        errors++;
        $display("FAIL reset_state[%0d] got v=%b d=%h e=%b a=%b c=%0d r=%b want zeros, in_ready=1",
                 i, out_valid_s[i], out_data_s[i], perr_s[i], abort_s[i], errcnt_s[i], in_ready_s[i]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int st;
    logic [7:0] words [3] = '{8'hA5, 8'hA5, 8'h01};
    logic       pars  [3] = '{1'b0, 1'b1, 1'b1};
    logic       errs  [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] cnts  [3] = '{8'd0, 8'd1, 8'd1};
    for (int n = 0; n < 3; n++) begin
      send_frame(0, words[n], pars[n], 1'b1, 1'b0, st);
      @(negedge clk);
      checks++;
      if (out_valid_s[0] !== 1'b1 || out_data_s[0] !== words[n] ||
          perr_s[0] !== errs[n] || errcnt_s[0] !== cnts[n]) begin
        errors++;
        $display("FAIL basic_frame%0d got v=%b d=%h e=%b c=%0d want v=1 d=%h e=%b c=%0d",
                 n, out_valid_s[0], out_data_s[0], perr_s[0], errcnt_s[0], words[n], errs[n], cnts[n]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int st;
    out_ready_s[0] = 1'b0;
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0, st);
    for (int k = 0; k < 8; k++) begin
      send_bit(0, 1'b1, 1'b0, st);
      checks++;
      if (st != 0) begin
        errors++;
        $display("FAIL bp_data_stall bit%0d got %0d stall cycles want 0", k, st);
      end
    end
    in_bit_s[0] = 1'b0;
    in_valid_s[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready_s[0] !== 1'b0 || out_data_s[0] !== 8'h3C || out_valid_s[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold got r=%b v=%b d=%h want r=0 v=1 d=3c",
                 in_ready_s[0], out_valid_s[0], out_data_s[0]);
      end
      @(posedge clk); #1;
    end
    out_ready_s[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_comb got %b want 1", in_ready_s[0]);
    end
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    exp_q[0].push_back({1'b0, 8'hFF});
    @(negedge clk);
    checks++;
    if (out_valid_s[0] !== 1'b1 || out_data_s[0] !== 8'hFF || perr_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_swap got v=%b d=%h e=%b want v=1 d=ff e=0",
               out_valid_s[0], out_data_s[0], perr_s[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int st;
    int a0;
    a0 = abort_seen[0];
    send_bit(0, 1'b1, 1'b0, st);
    send_bit(0, 1'b0, 1'b0, st);
    send_bit(0, 1'b1, 1'b0, st);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0, st);
    @(negedge clk);
    checks++;
    if (out_valid_s[0] !== 1'b1 || out_data_s[0] !== 8'h81 || perr_s[0] !== 1'b0 ||
        abort_seen[0] - a0 != 1) begin
      errors++;
      $display("FAIL abort got v=%b d=%h e=%b pulses=%0d want v=1 d=81 e=0 pulses=1",
               out_valid_s[0], out_data_s[0], perr_s[0], abort_seen[0] - a0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int st;
    int total;
    total = 0;
    for (int n = 0; n < 10; n++) begin
      send_frame(0, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, st);
      total += st;
    end
    checks++;
    if (total != 0) begin
      errors++;
      $display("FAIL b2b_stalls got %0d want 0", total);
    end
  endtask

  task automatic test_random();
    int st;
    int a0 [2];
    rand_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a0[i] = abort_seen[i];
      for (int n = 0; n < 40; n++) begin
        send_frame(i, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, st);
        if ($urandom_range(0, 2) == 0) idle(i, $urandom_range(1, 4));
      end
    end
    rand_ready = 1'b0;
    out_ready_s[0] = 1'b1;
    out_ready_s[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (exp_q[i].size() != 0 || abort_seen[i] != a0[i]) begin
        errors++;
        $display("FAIL random_drain[%0d] got pending=%0d pulses=%0d want 0 0",
                 i, exp_q[i].size(), abort_seen[i] - a0[i]);
      end
    end
  endtask

  task automatic test_odd();
    int st;
    send_frame(1, 8'h00, 1'b1, 1'b1, 1'b0, st);
    @(negedge clk);
    checks++;
    if (out_valid_s[1] !== 1'b1 || out_data_s[1] !== 8'h00 || perr_s[1] !== 1'b0) begin
      errors++;
      $display("FAIL odd_good got v=%b d=%h e=%b want v=1 d=00 e=0",
               out_valid_s[1], out_data_s[1], perr_s[1]);
    end
    @(posedge clk); #1;
    send_frame(1, 8'h00, 1'b0, 1'b1, 1'b0, st);
    @(negedge clk);
    checks++;
    if (out_valid_s[1] !== 1'b1 || perr_s[1] !== 1'b1 || errcnt_s[1] !== 8'(exp_cnt[1])) begin
      errors++;
      $display("FAIL odd_bad got v=%b e=%b c=%0d want v=1 e=1 c=%0d",
               out_valid_s[1], perr_s[1], errcnt_s[1], exp_cnt[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int st;
    logic [7:0] w;
    for (int n = 0; n < 260; n++) begin
      w = 8'($urandom);
      send_frame(0, w, ~(^w), 1'b1, 1'b0, st);
    end
    @(negedge clk);
    checks++;
    if (errcnt_s[0] !== 8'd255) begin
      errors++;
      $display("FAIL saturation got %0d want 255", errcnt_s[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midframe();
    int st;
    for (int k = 0; k < 5; k++) send_bit(0, 1'($urandom_range(0, 1)), 1'b0, st);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid_s[i], out_data_s[i], perr_s[i], abort_s[i], errcnt_s[i]} !== 18'b0) begin
        errors++;
        $display("FAIL reset_async[%0d] got v=%b d=%h e=%b a=%b c=%0d want all 0",
                 i, out_valid_s[i], out_data_s[i], perr_s[i], abort_s[i], errcnt_s[i]);
      end
      exp_q[i].delete();
      exp_cnt[i] = 0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, st);
    @(negedge clk);
    checks++;
    if (out_valid_s[0] !== 1'b1 || out_data_s[0] !== 8'h5A || perr_s[0] !== 1'b0 ||
        errcnt_s[0] !== 8'd0) begin
      errors++;
      $display("FAIL reset_then_frame got v=%b d=%h e=%b c=%0d want v=1 d=5a e=0 c=0",
               out_valid_s[0], out_data_s[0], perr_s[0], errcnt_s[0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_random();
    test_odd();
    test_saturation();
    test_reset_midframe();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Receive end of the team's parity-protected serial bit link: XOR-accumulates incoming bits, deserializes WIDTH data bits (LSB first), then checks the trailing parity bit.
- Presents each completed word with a parity-error flag on a valid/ready output register.
- Counts parity failures and flags frames aborted by a start-of-frame marker.
- Counterpart of the transmit-side parity generator built from the Xor primitive.

Parameters:
WIDTH, 8, data bits per frame (2..32)
ODD_PARITY, 0, 0 = even parity (XOR of data+parity must be 0), 1 = odd parity (must be 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_bit  input  1  serial bit
in_sof  input  1  qualifies in_bit as data bit 0 of a new frame
in_valid  input  1  in_bit/in_sof valid
in_ready  output  1  bit accepted when in_valid && in_ready
out_data  output  WIDTH  received data word
out_parity_err  output  1  parity check failed for out_data
out_valid  output  1  out_data/out_parity_err valid
out_ready  input  1  consumer accepts when out_valid && out_ready
out_abort  output  1  one-cycle pulse: partial frame discarded by in_sof
err_count  output  8  saturating count of frames with parity error

Behaviour:
- Reset (async, rst_n=0): bit counter cnt=0, shift reg=0, running parity acc=0, out_data=0, out_parity_err=0, out_valid=0, out_abort=0, err_count=0. Any partial frame is lost; the first bit accepted after reset is data bit 0.
- Phases by cnt: DATA (cnt 0..WIDTH-1), PARITY (cnt==WIDTH).
- in_ready: 1 in DATA; in PARITY, in_ready = !out_valid || out_ready (combinational from out_ready). Data bits never stall.
- Accepted bit with in_sof=1: treated as bit 0 of a new frame: shift[0]=in_bit, acc=in_bit, cnt=1. out_abort pulses next cycle iff cnt was nonzero. Applies in any phase where in_ready=1.
- Accepted bit in DATA with in_sof=0: shift[cnt]=in_bit, acc^=in_bit, cnt++.
- Accepted bit in PARITY with in_sof=0:
  - Load out_data=shift, out_parity_err=(acc^in_bit)!=ODD_PARITY, out_valid=1.
  - cnt=0, acc=0.
  - If error, err_count++ saturating at 255.
- Latency: out_valid rises the cycle after the parity bit is accepted. Back-to-back frames are sustainable at one bit per clock when out_ready=1.
- Output handshake:
  - out_valid && out_ready with no load that cycle: out_valid falls next cycle; out_data and out_parity_err hold their values.
  - Consume and load in the same cycle: out_valid stays 1 with the new frame. No bubble, no loss.
  - out_data and out_parity_err are stable while out_valid && !out_ready.
- in_valid=0: no state change; gaps between bits are allowed anywhere.
- in_sof=1 on a non-accepted cycle (in_valid=0, or in_ready=0): ignored.
- out_abort never coincides with a frame load. err_count never wraps.

Test Plan:
- ODD_PARITY=0, WIDTH=8, out_ready=1: send 0xA5 LSB-first (bits 1,0,1,0,0,1,0,1), then parity 0 -> one cycle later out_valid=1, out_data=0xA5, out_parity_err=0, err_count=0.
- Same frame with parity 1 -> out_parity_err=1, err_count=1. Next frame 0x01 with parity 1 -> err=0, err_count stays 1.
- Backpressure, out_ready=0:
  - Frame 0x3C completes; stream 8 data bits of 0xFF -> all accepted.
  - Parity bit sees in_ready=0; out_data stays 0x3C.
  - Raise out_ready -> 0x3C consumed and 0xFF loaded in the same cycle, out_valid stays 1.
- Abort: 3 data bits, then in_sof=1 with bit 1, then 7 bits + parity for 0x81 -> out_abort pulses once; output is 0x81, err=0.
- Saturation: 260 consecutive bad-parity frames -> err_count=255 thereafter. rst_n low mid-frame (after 5 bits) -> all outputs 0 immediately; next full frame 0x5A decodes correctly.
- ODD_PARITY=1: 0x00 with parity 1 -> err=0. 0x00 with parity 0 -> err=1.
